// File: rtl/accelerator_fifo_port.sv
// Router <-> accelerator port: two independent circular FIFOs with sticky error flags.
// Latency: one cycle from an accepted read request to registered data/valid; status flags registered.
// Backpressure: writes into a full FIFO are dropped unless a same-cycle read frees a slot; reads of an empty FIFO are ignored.

module fifo_core #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_vld,
    output logic             empty,
    output logic             full,
    output logic             wr_drop,
    output logic             rd_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    always_comb begin
        rd_ok   = rd_en && (count != '0);
        wr_ok   = wr_en && ((count != FULL_CNT) || rd_ok);
        wr_drop = wr_en && !wr_ok;
        rd_drop = rd_en && !rd_ok;
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer width is log2(DEPTH), so increments wrap from DEPTH-1 to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rd_dat <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_dat <= mem[rd_ptr];
            end
            rd_vld <= rd_ok;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == FULL_CNT);
        end
    end
endmodule

module accelerator_fifo_port #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put_req,
    input  logic             get_req,
    input  logic [WIDTH-1:0] router_data_in,
    output logic [WIDTH-1:0] router_data_out,
    output logic             router_data_valid,
    output logic             to_empty,
    output logic             to_full,
    output logic             from_empty,
    output logic             from_full,
    input  logic             acc_get,
    output logic [WIDTH-1:0] acc_data_out,
    output logic             acc_data_valid,
    input  logic             acc_put,
    input  logic [WIDTH-1:0] acc_data_in,
    output logic             overflow,
    output logic             underflow,
    output logic             proto_err
);
    logic proto_hit;
    logic to_wr_drop;
    logic to_rd_drop;
    logic from_wr_drop;
    logic from_rd_drop;

    // A simultaneous router put and get is a protocol violation; neither is performed.
    assign proto_hit = put_req && get_req;

    fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_to_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (put_req && !get_req),
        .wr_dat  (router_data_in),
        .rd_en   (acc_get),
        .rd_dat  (acc_data_out),
        .rd_vld  (acc_data_valid),
        .empty   (to_empty),
        .full    (to_full),
        .wr_drop (to_wr_drop),
        .rd_drop (to_rd_drop)
    );

    fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_from_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (acc_put),
        .wr_dat  (acc_data_in),
        .rd_en   (get_req && !put_req),
        .rd_dat  (router_data_out),
        .rd_vld  (router_data_valid),
        .empty   (from_empty),
        .full    (from_full),
        .wr_drop (from_wr_drop),
        .rd_drop (from_rd_drop)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= overflow  | to_wr_drop | from_wr_drop;
            underflow <= underflow | to_rd_drop | from_rd_drop;
            proto_err <= proto_err | proto_hit;
        end
    end
endmodule

// File: tb/tb_accelerator_fifo_port.sv
// Directed bench for accelerator_fifo_port at DEPTH=4.
module tb_accelerator_fifo_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        put_req, get_req, acc_get, acc_put;
    logic [31:0] router_data_in, acc_data_in;
    logic [31:0] router_data_out, acc_data_out;
    logic        router_data_valid, acc_data_valid;
    logic        to_empty, to_full, from_empty, from_full;
    logic        overflow, underflow, proto_err;
    int          checks = 0;
    int          errors = 0;

    accelerator_fifo_port #(.DEPTH(4), .WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .put_req           (put_req),
        .get_req           (get_req),
        .router_data_in    (router_data_in),
        .router_data_out   (router_data_out),
        .router_data_valid (router_data_valid),
        .to_empty          (to_empty),
        .to_full           (to_full),
        .from_empty        (from_empty),
        .from_full         (from_full),
        .acc_get           (acc_get),
        .acc_data_out      (acc_data_out),
        .acc_data_valid    (acc_data_valid),
        .acc_put           (acc_put),
        .acc_data_in       (acc_data_in),
        .overflow          (overflow),
        .underflow         (underflow),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One edge, then settle #1 past it and release all request strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        put_req = 1'b0;
        get_req = 1'b0;
        acc_get = 1'b0;
        acc_put = 1'b0;
    endtask

    task automatic put(input logic [31:0] d);
        put_req = 1'b1;
        router_data_in = d;
        tick();
    endtask

    task automatic pop(input logic [31:0] exp, input string tag);
        acc_get = 1'b1;
        tick();
        chk({tag, "_data"}, acc_data_out, exp);
        chk({tag, "_vld"}, acc_data_valid, 1);
    endtask

    initial begin
        reset = 1'b0;
        put_req = 1'b0; get_req = 1'b0; acc_get = 1'b0; acc_put = 1'b0;
        router_data_in = '0; acc_data_in = '0;
        tick(); tick();
        chk("rst_to_empty", to_empty, 1);
        chk("rst_from_empty", from_empty, 1);
        chk("rst_to_full", to_full, 0);
        chk("rst_from_full", from_full, 0);
        chk("rst_acc_vld", acc_data_valid, 0);
        chk("rst_rtr_vld", router_data_valid, 0);
        chk("rst_acc_data", acc_data_out, 0);
        chk("rst_rtr_data", router_data_out, 0);
        chk("rst_errs", {overflow, underflow, proto_err}, 0);
        reset = 1'b1;
        tick();

        // Fill and drain the to-FIFO
        put(32'h11); put(32'h22); put(32'h33);
        chk("fill3_full", to_full, 0);
        put(32'h44);
        chk("fill4_full", to_full, 1);
        chk("fill4_empty", to_empty, 0);
        pop(32'h11, "pop1"); pop(32'h22, "pop2"); pop(32'h33, "pop3");
        chk("pop3_empty", to_empty, 0);
        pop(32'h44, "pop4");
        chk("pop4_empty", to_empty, 1);
        chk("pop4_full", to_full, 0);
        tick();
        chk("idle_acc_vld", acc_data_valid, 0);
        chk("idle_acc_hold", acc_data_out, 32'h44);

        // Write while full with a concurrent read, then a dropped write
        put(32'h11); put(32'h22); put(32'h33); put(32'h44);
        put_req = 1'b1; router_data_in = 32'h55; acc_get = 1'b1;
        tick();
        chk("fullrw_data", acc_data_out, 32'h11);
        chk("fullrw_full", to_full, 1);
        chk("fullrw_ovf", overflow, 0);
        pop(32'h22, "after_fullrw");
        chk("after_fullrw_full", to_full, 0);
        put(32'h66);
        chk("refill_full", to_full, 1);
        put(32'h77);
        chk("drop_ovf", overflow, 1);
        chk("drop_full", to_full, 1);
        pop(32'h33, "drain1"); pop(32'h44, "drain2");
        pop(32'h55, "drain3"); pop(32'h66, "drain4");
        chk("drain_empty", to_empty, 1);
        tick();
        chk("ovf_sticky", overflow, 1);

        // Underflow on the from-FIFO, then a normal accelerator -> router transfer
        get_req = 1'b1;
        tick();
        chk("unf_flag", underflow, 1);
        chk("unf_vld", router_data_valid, 0);
        chk("unf_hold", router_data_out, 0);
        acc_put = 1'b1; acc_data_in = 32'hA5;
        tick();
        chk("aput_from_empty", from_empty, 0);
        get_req = 1'b1;
        tick();
        chk("get_data", router_data_out, 32'hA5);
        chk("get_vld", router_data_valid, 1);
        chk("get_from_empty", from_empty, 1);
        tick();
        chk("get_vld_drop", router_data_valid, 0);
        chk("get_hold", router_data_out, 32'hA5);

        // put_req and get_req together: protocol error, neither FIFO moves
        put(32'h99);
        acc_put = 1'b1; acc_data_in = 32'hBB;
        tick();
        chk("proto_pre", proto_err, 0);
        put_req = 1'b1; get_req = 1'b1; router_data_in = 32'hCC;
        tick();
        chk("proto_flag", proto_err, 1);
        chk("proto_rtr_vld", router_data_valid, 0);
        chk("proto_from_empty", from_empty, 0);
        pop(32'h99, "proto_pop");
        chk("proto_to_empty", to_empty, 1);
        get_req = 1'b1;
        tick();
        chk("proto_get", router_data_out, 32'hBB);
        chk("proto_get_empty", from_empty, 1);

        // Ten write/read pairs per FIFO wrap the pointers past DEPTH
        for (int i = 0; i < 10; i++) begin
            put_req = 1'b1; router_data_in = 32'h100 + i;
            acc_put = 1'b1; acc_data_in = 32'h200 + i;
            tick();
            acc_get = 1'b1;
            tick();
            get_req = 1'b1;
            tick();
            chk($sformatf("wrap_acc%0d", i), acc_data_out, 32'h100 + i);
            chk($sformatf("wrap_rtr%0d", i), router_data_out, 32'h200 + i);
            chk($sformatf("wrap_vld%0d", i), router_data_valid, 1);
        end
        chk("wrap_to_empty", to_empty, 1);
        chk("wrap_from_empty", from_empty, 1);

        // Reset mid-stream discards stored words; requests on reset edges are ignored
        put(32'hD1); put(32'hD2);
        acc_put = 1'b1; acc_data_in = 32'hE1;
        tick();
        reset = 1'b0; put_req = 1'b1; router_data_in = 32'hF0; acc_get = 1'b1;
        tick();
        chk("mrst_to_empty", to_empty, 1);
        chk("mrst_from_empty", from_empty, 1);
        chk("mrst_errs", {overflow, underflow, proto_err}, 0);
        chk("mrst_acc_data", acc_data_out, 0);
        chk("mrst_rtr_data", router_data_out, 0);
        chk("mrst_vlds", {acc_data_valid, router_data_valid}, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_to_empty", to_empty, 1);
        acc_get = 1'b1;
        tick();
        chk("post_rst_unf", underflow, 1);
        chk("post_rst_vld", acc_data_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accelerator_fifo_port.md
ACCELERATOR_FIFO_PORT -- requirements
Module: accelerator_fifo_port

Interface
REQ-001 Parameter: DEPTH, default 16, entries per FIFO; SHALL be a power of two and at least 2.
REQ-002 Parameter: WIDTH, default 32, data word width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 put_req  input  1  router writes router_data_in into the to-FIFO.
REQ-007 get_req  input  1  router reads one word from the from-FIFO.
REQ-008 router_data_in  input  WIDTH  data from router toward the accelerator.
REQ-009 router_data_out  output  WIDTH  data from the from-FIFO to the router.
REQ-010 router_data_valid  output  1  router_data_out holds a newly read word.
REQ-011 to_empty, to_full  output  1 each  to-FIFO status.
REQ-012 from_empty, from_full  output  1 each  from-FIFO status.
REQ-013 acc_get  input  1  accelerator pops one word from the to-FIFO.
REQ-014 acc_data_out  output  WIDTH  to-FIFO word delivered to the accelerator.
REQ-015 acc_data_valid  output  1  acc_data_out holds a newly popped word.
REQ-016 acc_put  input  1  accelerator pushes acc_data_in into the from-FIFO.
REQ-017 acc_data_in  input  WIDTH  accelerator result data.
REQ-018 overflow, underflow, proto_err  output  1 each  sticky error flags.

Function
REQ-019 The block SHALL contain two independent circular FIFOs: to-FIFO (router writes, accelerator reads) and from-FIFO (accelerator writes, router reads), each with a write pointer, a read pointer and an occupancy count of 0..DEPTH.
REQ-020 Pointers SHALL increment by one per accepted operation and wrap from DEPTH-1 to 0.
REQ-021 A write SHALL be accepted when the FIFO is not full, or when it is full and a read of the same FIFO is accepted in the same cycle.
REQ-022 A read SHALL be accepted only when the count is nonzero; a write into an empty FIFO SHALL NOT be bypassed to the read port in the same cycle.
REQ-023 Count update SHALL be +1 (write only), -1 (read only), or unchanged (both or neither).
REQ-024 Read data SHALL be registered: an accepted read SHALL drive its data_out port and assert the matching valid output for exactly one cycle, on the edge following the request; otherwise valid SHALL be 0 and data_out SHALL hold its last value.
REQ-025 Empty and full flags SHALL be registered and SHALL reflect the count after the current edge: empty = (count==0), full = (count==DEPTH).
REQ-026 put_req and get_req asserted together SHALL perform neither operation and SHALL set proto_err.
REQ-027 A write refused under REQ-021 SHALL drop the data, leave the FIFO unchanged and set overflow.
REQ-028 A read request on an empty FIFO SHALL be ignored and SHALL set underflow.
REQ-029 overflow, underflow and proto_err SHALL remain set until reset.
REQ-030 Router-side and accelerator-side operations SHALL be evaluated concurrently in the same cycle without priority between the two sides.

Reset
REQ-031 While reset is 0 at a clock edge, the block SHALL clear all pointers and counts, set to_empty and from_empty to 1, and drive all other outputs (data, valids, full flags, error flags) to 0.
REQ-032 A reset asserted mid-transfer SHALL discard all stored words; requests sampled on a reset edge SHALL have no effect.
REQ-033 Memory array contents need not be reset.

Verification (DEPTH=4)
REQ-034 Scenario: after reset, put_req writes 0x11, 0x22, 0x33 and 0x44 -> to_full=1 and to_empty=0 after the 4th edge; then acc_get x4 -> acc_data_out 0x11, 0x22, 0x33, 0x44 with acc_data_valid=1 each cycle, then to_empty=1.
REQ-035 Scenario: to-FIFO full, put_req 0x55 together with acc_get -> write accepted, count stays 4, next pop yields 0x22, overflow=0; a later put_req while full with no acc_get -> overflow=1 and the data is dropped.
REQ-036 Scenario: get_req with from-FIFO empty -> underflow=1, router_data_valid=0, router_data_out unchanged; acc_put 0xA5 then get_req -> router_data_out=0xA5 with valid for one cycle.
REQ-037 Scenario: put_req and get_req asserted in the same cycle -> proto_err=1 and both FIFO counts unchanged.
REQ-038 Scenario: run 10 write/read pairs through each FIFO -> pointers wrap correctly and the data order is preserved; then reset=0 mid-stream -> both empty flags=1 and all errors, valids and data outputs=0.
